// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit 7-segment scanner: segment table,
// off patterns and register-select encodings.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] SEL_OFF = 4'hF;

  localparam logic REG_VALUE = 1'b0;
  localparam logic REG_CTRL  = 1'b1;

  // Active-low {dp, g..a} per hex nibble; entry 0 is the rightmost element.
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble plus decimal point to active-low 7-segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  assign seg_o = {~dp_i, HEX_SEG[nibble_i][6:0]};

endmodule

// File: rtl/seg7_scanner.sv
// Memory-mapped 4-digit display scanner: VALUE/CTRL registers, prescaled
// digit rotor with a dead cycle at the start of each slot, registered outputs.
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        wsel,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic [3:0]  disp_sel,
  output logic [7:0]  disp_dig
);

  localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  SEL_IDLE = ACTIVE_LOW ? SEL_OFF : ~SEL_OFF;
  localparam logic [7:0]  DIG_IDLE = ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;

  logic [15:0] value_q, value_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  sel_q, sel_d;
  logic [7:0]  dig_q, dig_d;

  logic [3:0]  digit_onehot;
  logic [3:0]  nibble;
  logic        dp_on;
  logic        blank;
  logic [7:0]  seg_raw;
  logic [3:0]  sel_raw;
  logic [7:0]  dig_raw;

  always_comb begin
    value_d = value_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    if (we) begin
      if (wsel == REG_CTRL) ctrl_d = wdata[7:0];
      else                  value_d = wdata;
    end
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Outputs are computed from the post-edge slot position so the driven
  // digit lines up with the counter phase it belongs to.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
      assign digit_onehot[gi] = (idx_d == 2'(gi));
    end
  endgenerate

  assign nibble = value_q[{idx_d, 2'b00} +: 4];
  assign dp_on  = ctrl_q[{1'b1, idx_d}];
  assign blank  = ctrl_q[{1'b0, idx_d}];

  seg7_decode u_decode (
    .nibble_i (nibble),
    .dp_i     (dp_on),
    .seg_o    (seg_raw)
  );

  always_comb begin
    sel_raw = SEL_OFF;
    dig_raw = SEG_OFF;
    if (cnt_d != 16'd0 && !blank) begin
      sel_raw = ~digit_onehot;
      dig_raw = seg_raw;
    end
    sel_d = ACTIVE_LOW ? sel_raw : ~sel_raw;
    dig_d = ACTIVE_LOW ? dig_raw : ~dig_raw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      sel_q   <= SEL_IDLE;
      dig_q   <= DIG_IDLE;
    end else begin
      value_q <= value_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      dig_q   <= dig_d;
    end
  end

  assign rdata    = (wsel == REG_CTRL) ? {8'h00, ctrl_q} : value_q;
  assign disp_sel = sel_q;
  assign disp_dig = dig_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// Scoreboard bench for seg7_scanner with SCAN_DIV=4: stimulus queues
// cycle-tagged expectations, a negedge monitor pops and compares them.
module tb_seg7_scanner;

  localparam int B    = 3;   // edge count at the last reset-high edge
  localparam int K_LO = 0;
  localparam int K_HI = 1;
  localparam int K_RD = 2;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        we, wsel;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic [3:0]  disp_sel;
  logic [7:0]  disp_dig;

  logic        we_h, wsel_h;
  logic [15:0] wdata_h;
  logic [15:0] rdata_h;
  logic [3:0]  disp_sel_h;
  logic [7:0]  disp_dig_h;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t mon_e;
  logic [15:0] mon_act;

  seg7_scanner #(.SCAN_DIV(4), .ACTIVE_LOW(1'b1)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .wsel     (wsel),
    .wdata    (wdata),
    .rdata    (rdata),
    .disp_sel (disp_sel),
    .disp_dig (disp_dig)
  );

  seg7_scanner #(.SCAN_DIV(4), .ACTIVE_LOW(1'b0)) u_dut_hi (
    .clk      (clk),
    .reset    (reset),
    .we       (we_h),
    .wsel     (wsel_h),
    .wdata    (wdata_h),
    .rdata    (rdata_h),
    .disp_sel (disp_sel_h),
    .disp_dig (disp_dig_h)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      case (mon_e.kind)
        K_LO:    mon_act = {4'h0, disp_sel, disp_dig};
        K_HI:    mon_act = {4'h0, disp_sel_h, disp_dig_h};
        default: mon_act = rdata;
      endcase
      checks++;
      if (mon_e.cyc != cyc || mon_act !== mon_e.val) begin
        errors++;
        $display("FAIL %s cyc=%0d: got %h expected %h (due cyc %0d)",
                 mon_e.name, cyc, mon_act, mon_e.val, mon_e.cyc);
      end else begin
        $display("ok   %s cyc=%0d: %h", mon_e.name, cyc, mon_act);
      end
    end
  end

  task automatic push(input int k, input int kind, input logic [15:0] v, input string n);
    exp_t e;
    e.cyc  = B + k;
    e.kind = kind;
    e.val  = v;
    e.name = n;
    q.push_back(e);
  endtask

  // One slot: dead cycle at k_dead, then three driven cycles.
  task automatic slot(input int k_dead, input logic [3:0] sel, input logic [7:0] dig, input string n);
    push(k_dead, K_LO, {4'h0, 4'hF, 8'hFF}, {n, "_dead"});
    for (int i = 1; i <= 3; i++) push(k_dead + i, K_LO, {4'h0, sel, dig}, n);
  endtask

  task automatic goto(input int k);
    while (cyc < B + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; wsel = 1'b0; wdata = '0;
    we_h = 1'b0; wsel_h = 1'b0; wdata_h = '0;
    repeat (B) @(posedge clk);
    #1;

    // Reset state, first rotation with VALUE=0; polarity DUT loads 0008.
    push(0, K_RD, 16'h0000, "reset_rdata");
    push(0, K_LO, {4'h0, 4'hF, 8'hFF}, "reset_off");
    push(0, K_HI, {4'h0, 4'h0, 8'h00}, "hi_reset_off");
    push(1, K_LO, {4'h0, 4'hE, 8'hC0}, "d0_zero");
    push(2, K_LO, {4'h0, 4'hE, 8'hC0}, "d0_zero");
    push(2, K_HI, {4'h0, 4'h1, 8'h7F}, "hi_d0_eight");
    push(3, K_LO, {4'h0, 4'hE, 8'hC0}, "d0_zero");
    push(3, K_HI, {4'h0, 4'h1, 8'h7F}, "hi_d0_eight");
    push(4, K_LO, {4'h0, 4'hF, 8'hFF}, "d1_dead");
    push(5, K_LO, {4'h0, 4'hD, 8'hC0}, "d1_zero");
    push(5, K_HI, {4'h0, 4'h2, 8'h3F}, "hi_d1_zero");
    push(6, K_LO, {4'h0, 4'hD, 8'hC0}, "d1_zero");
    push(7, K_LO, {4'h0, 4'hD, 8'hC0}, "d1_zero");
    reset = 1'b0;
    we_h = 1'b1; wsel_h = 1'b0; wdata_h = 16'h0008;
    goto(1);
    we_h = 1'b0;

    // VALUE=BEEF written during digit 2's dead cycle, then a full rotation.
    goto(7);
    push(8, K_RD, 16'hBEEF, "rdata_value");
    for (int k = 9; k <= 11; k++) push(k, K_LO, {4'h0, 4'hB, 8'h86}, "beef_d2");
    slot(12, 4'h7, 8'h83, "beef_d3");
    slot(16, 4'hE, 8'h8E, "beef_d0");
    slot(20, 4'hD, 8'h86, "beef_d1");
    push(24, K_LO, {4'h0, 4'hF, 8'hFF}, "beef_d2_dead");
    we = 1'b1; wsel = 1'b0; wdata = 16'hBEEF;
    goto(8);
    we = 1'b0;

    // CTRL=21: digit 0 blanked, digit 1 dp lit.
    goto(24);
    push(25, K_RD, 16'h0021, "rdata_ctrl");
    push(26, K_LO, {4'h0, 4'hB, 8'h86}, "ctrl_d2");
    push(27, K_LO, {4'h0, 4'hB, 8'h86}, "ctrl_d2");
    slot(28, 4'h7, 8'h83, "ctrl_d3");
    slot(32, 4'hF, 8'hFF, "blank_d0");
    slot(36, 4'hD, 8'h06, "dp_d1");
    we = 1'b1; wsel = 1'b1; wdata = 16'h0021;
    goto(25);
    we = 1'b0;
    goto(26);
    wsel = 1'b0;

    // VALUE=1000 captured on the wrap edge entering digit 3.
    goto(43);
    push(43, K_LO, {4'h0, 4'hB, 8'h86}, "pre_wrap_d2");
    slot(44, 4'h7, 8'hF9, "wrap_d3");
    we = 1'b1; wsel = 1'b0; wdata = 16'h1000;
    goto(44);
    we = 1'b0;

    // Reset during digit 2's slot with a colliding write.
    goto(57);
    push(57, K_LO, {4'h0, 4'hB, 8'hC0}, "pre_rst_d2");
    push(58, K_LO, {4'h0, 4'hF, 8'hFF}, "midrst_off");
    push(58, K_RD, 16'h0000, "midrst_rdata");
    push(59, K_LO, {4'h0, 4'hE, 8'hC0}, "post_rst_d0");
    push(59, K_RD, 16'h0000, "post_rst_rdata");
    reset = 1'b1; we = 1'b1; wsel = 1'b0; wdata = 16'hABCD;
    goto(58);
    reset = 1'b0; we = 1'b0;

    goto(60);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
